costas_phase_detector: RTL
==========================

COSTAS_PHASE_DETECTOR -- requirements
Module: costas_phase_detector

Interface
REQ-001 SHALL have parameter INTEG_LEN, default 16: valid samples per integrate-and-dump window (2..255).
REQ-002 SHALL have parameter ACC_W, default 8: signed I/Q accumulator width.
REQ-003 SHALL have parameter PHASE_W, default 8: loop-filter phase accumulator width (>=3).
REQ-004 SHALL have parameter GAIN_SHIFT, default 2: arithmetic right shift applied to the discriminator.
REQ-005 SHALL have parameter LOCK_CNT, default 4: consecutive dumps needed to change lock state.
REQ-006 SHALL have ports: clk  input  1  clock; rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have ports: sample_in  input  1  IF sign bit; sample_valid  input  1  sample qualifier.
REQ-008 SHALL have ports: sine  input  1  and cosine  input  1  NCO outputs, aligned with sample_in.
REQ-009 SHALL have ports: phase_error  output  2  NCO phase offset; err_valid  output  1  update strobe; locked  output  1  lock flag.

Function
REQ-010 SHALL map bit 1 = +1 and bit 0 = -1; i_term = sample_in XNOR cosine and q_term = sample_in XNOR sine.
REQ-011 SHALL, per valid sample, add i_term to I_acc and q_term to Q_acc, saturating at +/-(2^(ACC_W-1)-1); invalid cycles hold all state.
REQ-012 SHALL count valid samples 0..INTEG_LEN-1; on the valid sample at count INTEG_LEN-1 (dump cycle), latch I_dump/Q_dump including that sample, clear I_acc/Q_acc/count, and start the next window with the next valid sample.
REQ-013 SHALL compute d = Q_dump if I_dump >= 0, else -Q_dump, registered on the cycle after dump.
REQ-014 SHALL add (d >>> GAIN_SHIFT), sign-extended to PHASE_W, to loop_acc modulo 2^PHASE_W (wrap, no saturation).
REQ-015 SHALL drive phase_error = loop_acc[PHASE_W-1:PHASE_W-2], registered; it changes only on update.
REQ-016 SHALL pulse err_valid high for exactly one cycle, coincident with the new phase_error, two clk edges after the dump-cycle edge.
REQ-017 SHALL ignore sample_valid gaps of any length without losing or duplicating samples.

Reset
REQ-018 SHALL, on rst (async assert, sync deassert to clk), clear I_acc, Q_acc, count, loop_acc, pipeline, and lock counter; phase_error=2'b00, err_valid=0, locked=0, lock state ACQUIRE.
REQ-019 SHALL discard a partial window and any in-flight update when reset occurs mid-operation; no err_valid follows.

Configuration
REQ-020 SHALL, with COSTAS_LOCK_DET_EN defined, implement the ACQUIRE/TRACK lock FSM: at each dump, a "good" dump is |I_dump| > |Q_dump|; ACQUIRE->TRACK after LOCK_CNT consecutive good dumps; TRACK->ACQUIRE after LOCK_CNT consecutive bad dumps; the opposite outcome resets the run count.
REQ-021 SHALL drive locked=1 exactly in TRACK, updated together with err_valid.
REQ-022 SHALL, without COSTAS_LOCK_DET_EN, omit the FSM and tie locked to 0; all other behaviour is unchanged.

Structure
REQ-023 SHALL place the lock-state enum (ACQUIRE, TRACK), the bit-to-sign mapping constants and the parameter defaults in shared package costas_pkg.
REQ-024 SHALL instantiate sub-module costas_int_dump (saturating accumulate, dump, clear) twice, once per arm; the counter is shared in the parent.

Verification (INTEG_LEN=16, ACC_W=8, PHASE_W=8, GAIN_SHIFT=2, LOCK_CNT=4 unless stated)
REQ-025 SHALL cover: sample_in=cosine=sine, valid every cycle -> I=Q=+16, d=+16, loop_acc +=4; phase_error stays 00 for 15 updates and becomes 01 on the 16th.
REQ-026 SHALL cover: sample_in=cosine, sine=~cosine -> d=-16, loop_acc=252 after the first dump, phase_error=11 (wrap) with a single err_valid pulse.
REQ-027 SHALL cover: sample_valid every other cycle -> err_valid after exactly the 16th valid sample + 2 edges, with results identical to REQ-025.
REQ-028 SHALL cover (COSTAS_LOCK_DET_EN): sample_in=cosine with sine alternating per sample (I=16, Q=0) -> locked=1 on the 4th err_valid; then sample_in=sine with cosine alternating -> locked=0 on the 4th subsequent err_valid.
REQ-029 SHALL cover: rst pulse after 10 valid samples -> outputs at reset values, no err_valid, and the next dump only after 16 new valid samples.
REQ-030 SHALL cover: ACC_W=4 with all samples matching -> I_dump=Q_dump=+7 (saturated), d=+7, loop_acc +=1.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared types and constants for the Costas-loop phase detector.
// Lock-state enum, sample sign mapping and parameter defaults.
package costas_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } lock_state_e;

    // A '1' bit stands for +1 and a '0' bit for -1.
    localparam logic BIT_POS = 1'b1;
    localparam logic BIT_NEG = 1'b0;

    localparam int INTEG_LEN_DEF  = 16;
    localparam int ACC_W_DEF      = 8;
    localparam int PHASE_W_DEF    = 8;
    localparam int GAIN_SHIFT_DEF = 2;
    localparam int LOCK_CNT_DEF   = 4;

endpackage

// File: rtl/costas_int_dump.sv
// One integrate-and-dump arm: saturating +/-1 accumulate, latch the sum on dump.
// Saturation is symmetric so the dump value can always be negated safely.
module costas_int_dump
    import costas_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             term_i,
    input  logic             dump_i,
    output logic [ACC_W-1:0] dump_o
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] dump_q, dump_d;
    logic signed [ACC_W-1:0] sum;

    always_comb begin
        sum    = acc_q;
        acc_d  = acc_q;
        dump_d = dump_q;
        if (term_i == BIT_POS) begin
            if (acc_q != ACC_MAX) sum = acc_q + ACC_ONE;
        end else begin
            if (acc_q != ACC_MIN) sum = acc_q - ACC_ONE;
        end
        if (valid_i) begin
            if (dump_i) begin
                dump_d = sum;
                acc_d  = '0;
            end else begin
                acc_d  = sum;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            dump_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dump_q <= dump_d;
        end
    end

    assign dump_o = dump_q;

endmodule

// File: rtl/costas_phase_detector.sv
// Costas-loop phase detector: I/Q integrate-and-dump, sign discriminator, phase loop filter.
// Optional ACQUIRE/TRACK lock detector is built when COSTAS_LOCK_DET_EN is defined.
module costas_phase_detector
    import costas_pkg::*;
#(
    parameter int INTEG_LEN  = INTEG_LEN_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_in,
    input  logic       sample_valid,
    input  logic       sine,
    input  logic       cosine,
    output logic [1:0] phase_error,
    output logic       err_valid,
    output logic       locked
);

    localparam int EXT_W = (ACC_W > PHASE_W) ? ACC_W : PHASE_W;

    logic [7:0] count_q, count_d;
    logic       dump_w;
    logic       i_term, q_term;
    logic signed [ACC_W-1:0]   i_dump, q_dump;
    logic signed [ACC_W-1:0]   d_q, d_d, d_sh;
    logic signed [EXT_W-1:0]   step_ext;
    logic        [PHASE_W-1:0] loop_q, loop_d;
    logic       p1_q, p2_q;
    logic [1:0] phase_error_q;
    logic       err_valid_q;

    assign i_term = ~(sample_in ^ cosine);
    assign q_term = ~(sample_in ^ sine);
    assign dump_w = sample_valid && (count_q == 8'(INTEG_LEN - 1));

    always_comb begin
        count_d = count_q;
        if (sample_valid) count_d = dump_w ? 8'd0 : count_q + 8'd1;
    end

    costas_int_dump #(.ACC_W(ACC_W)) u_i_arm (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(sample_valid),
        .term_i (i_term),
        .dump_i (dump_w),
        .dump_o (i_dump)
    );

    costas_int_dump #(.ACC_W(ACC_W)) u_q_arm (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(sample_valid),
        .term_i (q_term),
        .dump_i (dump_w),
        .dump_o (q_dump)
    );

    // Sign of I resolves the BPSK ambiguity: Q is flipped when I is negative.
    assign d_d      = i_dump[ACC_W-1] ? -q_dump : q_dump;
    assign d_sh     = d_q >>> GAIN_SHIFT;
    assign step_ext = EXT_W'(d_sh);
    assign loop_d   = loop_q + step_ext[PHASE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            p1_q          <= 1'b0;
            p2_q          <= 1'b0;
            d_q           <= '0;
            loop_q        <= '0;
            phase_error_q <= 2'b00;
            err_valid_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            p1_q        <= dump_w;
            p2_q        <= p1_q;
            err_valid_q <= p2_q;
            if (p1_q) d_q <= d_d;
            if (p2_q) begin
                loop_q        <= loop_d;
                phase_error_q <= loop_d[PHASE_W-1:PHASE_W-2];
            end
        end
    end

    assign phase_error = phase_error_q;
    assign err_valid   = err_valid_q;

`ifdef COSTAS_LOCK_DET_EN
    // state   | meaning
    // ACQUIRE | searching; LOCK_CNT consecutive good dumps move to TRACK
    // TRACK   | locked; LOCK_CNT consecutive bad dumps return to ACQUIRE
    lock_state_e state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [ACC_W-1:0] i_abs, q_abs;
    logic        good_q;

    assign i_abs = i_dump[ACC_W-1] ? -i_dump : i_dump;
    assign q_abs = q_dump[ACC_W-1] ? -q_dump : q_dump;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (p2_q) begin
            if (good_q == (state_q == ACQUIRE)) begin
                if (run_q == 8'(LOCK_CNT - 1)) begin
                    state_d = (state_q == ACQUIRE) ? TRACK : ACQUIRE;
                    run_d   = '0;
                end else begin
                    run_d   = run_q + 8'd1;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACQUIRE;
            run_q   <= '0;
            good_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            if (p1_q) good_q <= (i_abs > q_abs);
        end
    end

    assign locked = (state_q == TRACK);
`else
    assign locked = 1'b0;
`endif

endmodule
